alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter TAG_W, default 4, SHALL set the width of the request tag echoed with each response (1..8).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  SHALL signal a pending operation from requester 0 / 1.
REQ-005 req0_ready / req1_ready  output  1 each  SHALL signal acceptance; a transfer occurs when valid and ready are both high at a rising edge.
REQ-006 reqN_in1, reqN_in2  input  32 each; reqN_func3  input  3; reqN_opequal  input  1; reqN_tag  input  TAG_W  SHALL be requester N's operands, function code, add/sub and logical/arith qualifier, and tag.
REQ-007 rsp_valid  output  1  SHALL flag a valid result on the shared response channel.
REQ-008 rsp_ready  input  1  SHALL be the consumer's acceptance of the response.
REQ-009 rsp_data  output  32; rsp_src  output  1; rsp_tag  output  TAG_W  SHALL carry the result, the winning requester index, and its echoed tag.

Function
REQ-010 The block SHALL contain exactly one instance of the team ALU (alu), fed from the granted requester's in1/in2/func3/opequal; no other arithmetic path SHALL exist.
REQ-011 The FSM SHALL have two states: IDLE (no result held) and RESP (result held, rsp_valid=1).
REQ-012 In IDLE with any reqN_valid high, the block SHALL grant one requester, assert only that reqN_ready, and on the edge register ALU out into rsp_data, plus rsp_src and rsp_tag, then enter RESP.
REQ-013 Latency SHALL be one cycle: accepted at edge N, rsp_valid high from edge N until the response handshake completes.
REQ-014 In RESP, rsp_data/rsp_src/rsp_tag SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-015 In RESP with rsp_ready=1, the block SHALL accept a new grant in the same cycle (back-to-back, one op per cycle); with no request pending it SHALL return to IDLE.
REQ-016 reqN_ready SHALL be high only for the granted requester and only when (state==IDLE) or rsp_ready=1; this combinational dependence on rsp_ready is required.
REQ-017 Arbitration SHALL be round-robin: a last_grant flop records the most recent winner; on simultaneous requests the other requester wins.
REQ-018 last_grant SHALL update only on an accepted transfer, not when a request is withdrawn or stalled.
REQ-019 A single request SHALL win regardless of last_grant.
REQ-020 reqN_ready SHALL not depend on reqN_valid of the same requester beyond grant selection (no valid->ready->valid loop).
REQ-021 ALU results SHALL match alu bit-for-bit, including SLT/SLTU, SRA with opequal=1, and shift amount in2[4:0].

Reset
REQ-022 On rst_n low, state SHALL become IDLE asynchronously; rsp_valid=0, rsp_data=0, rsp_src=0, rsp_tag=0, last_grant=1 (requester 0 wins first tie).
REQ-023 Reset during RESP SHALL discard the held result with no response delivered; reqN_ready SHALL be 0 while rst_n is low.
REQ-024 Reset deassertion SHALL take effect at the next rising edge; no transfer SHALL occur on that edge's preceding low period.

Configuration
REQ-025 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win simultaneous requests and last_grant SHALL be absent; when undefined, round-robin per REQ-017 SHALL apply.

Verification
REQ-026 Single op: req0 in1=5, in2=3, func3=000, opequal=1, tag=2 -> next cycle rsp_valid=1, rsp_data=2, rsp_src=0, rsp_tag=2.
REQ-027 Tie: both valid for 4 cycles, rsp_ready=1 -> grants 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-028 Backpressure: rsp_ready=0 for 3 cycles after SRA in1=0x80000000, in2=4, opequal=1 -> rsp_data=0xF8000000 stable, both req_ready=0, then one handshake.
REQ-029 Back-to-back: req1 valid 3 consecutive ops (SLT -1,1; SLTU -1,1; XOR 0xF0,0xFF), rsp_ready=1 -> results 1, 0, 0x0F on 3 consecutive cycles.
REQ-030 Reset mid-RESP: rst_n low while rsp_valid=1 -> rsp_valid=0 immediately; after release, a tie grants requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU, with a one-entry registered response.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); round-robin otherwise.

module alu (
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [2:0]  func3,
    input  logic        opequal,
    output logic [31:0] out
);
    always_comb begin
        out = '0;
        case (func3)
            3'b000: out = opequal ? (in1 - in2) : (in1 + in2);
            3'b001: out = in1 << in2[4:0];
            3'b010: out = {31'b0, $signed(in1) < $signed(in2)};
            3'b011: out = {31'b0, in1 < in2};
            3'b100: out = in1 ^ in2;
            3'b101: out = opequal ? 32'($signed(in1) >>> in2[4:0]) : (in1 >> in2[4:0]);
            3'b110: out = in1 | in2;
            3'b111: out = in1 & in2;
            default: out = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_in1,
    input  logic [31:0]      req0_in2,
    input  logic [2:0]       req0_func3,
    input  logic             req0_opequal,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_in1,
    input  logic [31:0]      req1_in2,
    input  logic [2:0]       req1_func3,
    input  logic             req1_opequal,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t           state_q, state_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_src_q, rsp_src_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             sel, can_accept, xfer;
    logic [31:0]      alu_out;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign sel = req1_valid & ~req0_valid;
`else
    logic last_grant_q, last_grant_d;

    // On a tie the requester that did not win last goes first.
    assign sel = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;

    always_comb begin
        last_grant_d = last_grant_q;
        if (xfer)
            last_grant_d = sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= 1'b1;
        else        last_grant_q <= last_grant_d;
    end
`endif

    // Ready follows grant and the output slot only, never the requester's own valid.
    assign can_accept = (state_q == IDLE) || rsp_ready;
    assign req0_ready = rst_n & can_accept & ~sel;
    assign req1_ready = rst_n & can_accept & sel;
    assign xfer       = (req0_valid | req1_valid) & can_accept;

    alu u_alu (
        .in1     (sel ? req1_in1     : req0_in1),
        .in2     (sel ? req1_in2     : req0_in2),
        .func3   (sel ? req1_func3   : req0_func3),
        .opequal (sel ? req1_opequal : req0_opequal),
        .out     (alu_out)
    );

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_src_d  = rsp_src_q;
        rsp_tag_d  = rsp_tag_q;
        case (state_q)
            IDLE: if (xfer) state_d = RESP;
            RESP: if (rsp_ready) state_d = xfer ? RESP : IDLE;
            default: state_d = IDLE;
        endcase
        if (xfer) begin
            rsp_data_d = alu_out;
            rsp_src_d  = sel;
            rsp_tag_d  = sel ? req1_tag : req0_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rsp_data_q <= '0;
            rsp_src_q  <= 1'b0;
            rsp_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_src_q  <= rsp_src_d;
            rsp_tag_q  <= rsp_tag_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_src   = rsp_src_q;
    assign rsp_tag   = rsp_tag_q;
endmodule
